// File: rtl/cache_fill_if.sv
`default_nettype none
// cache_fill_if: miss-request, memory-read and cache-fill signals shared by
// the fill controller (master) and the caches/memory around it (slave).
interface cache_fill_if;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        fill_we_i;
  logic        fill_we_d;
  logic        tag_we_i;
  logic        tag_we_d;
  logic        fill_busy;

  modport master (
    input  i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_in, mem_data_valid,
    output mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
           tag_we_i, tag_we_d, fill_busy
  );

  modport slave (
    output i_miss, i_miss_addr, d_miss, d_miss_addr, mem_data_in, mem_data_valid,
    input  mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
           tag_we_i, tag_we_d, fill_busy
  );
endinterface
`default_nettype wire

// File: rtl/cache_fill_ctrl.sv
`default_nettype none
// cache_fill_ctrl: shared I/D cache block-fill engine. Issues 8 pipelined word
// reads per miss (D has priority), streams returned words into the owner's data array.
module cache_fill_ctrl #(
  parameter int MEM_LATENCY = 4
) (
  input  logic         clk,
  input  logic         rst,
  cache_fill_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        owner_d;
  logic [11:0] blk;
  logic [2:0]  issue_k;
  logic [2:0]  recv_k;
  logic        grant;
  logic        grant_d;
  logic        rx;

  // The controller itself is latency-agnostic; only a nonsensical value is rejected.
  if (MEM_LATENCY < 0) begin : g_latency_check
    $error("cache_fill_ctrl: MEM_LATENCY must not be negative");
  end

  assign rx = bus.mem_data_valid && (state == ISSUE || state == DRAIN);

  always_comb begin
    state_nxt      = state;
    grant          = 1'b0;
    grant_d        = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_addr   = 16'h0000;
    bus.fill_data  = 16'h0000;
    bus.fill_word  = 3'd0;
    bus.fill_we_i  = 1'b0;
    bus.fill_we_d  = 1'b0;
    bus.tag_we_i   = 1'b0;
    bus.tag_we_d   = 1'b0;
    bus.fill_busy  = (state != IDLE);

    case (state)
      IDLE: begin
        if (bus.d_miss) begin
          grant     = 1'b1;
          grant_d   = 1'b1;
          state_nxt = ISSUE;
        end else if (bus.i_miss) begin
          grant     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_en   = 1'b1;
        bus.mem_addr = {blk, issue_k, 1'b0};
        if (issue_k == 3'd7) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = DRAIN;
      end
      DONE: begin
        bus.tag_we_i = ~owner_d;
        bus.tag_we_d = owner_d;
        state_nxt    = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // A receipt can overlap the last issue at very short latencies, so the
    // 8th word wins over the ISSUE->DRAIN transition.
    if (rx) begin
      bus.fill_data = bus.mem_data_in;
      bus.fill_word = recv_k;
      bus.fill_we_i = ~owner_d;
      bus.fill_we_d = owner_d;
      if (recv_k == 3'd7) begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      blk     <= 12'h000;
      issue_k <= 3'd0;
      recv_k  <= 3'd0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner_d <= grant_d;
        blk     <= grant_d ? bus.d_miss_addr[15:4] : bus.i_miss_addr[15:4];
        issue_k <= 3'd0;
        recv_k  <= 3'd0;
      end else begin
        if (state == ISSUE) begin
          issue_k <= issue_k + 3'd1;
        end
        if (rx) begin
          recv_k <= recv_k + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_ctrl.sv
`default_nettype none
// tb_cache_fill_ctrl: table-driven fills on a latency-4 controller checked by an
// issue/fill scoreboard, plus priority, reset, stray-data and latency-sweep sequences.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_fill_if bus0 ();
  cache_fill_if bus1 ();
  cache_fill_if bus2 ();

  cache_fill_ctrl #(.MEM_LATENCY(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  cache_fill_ctrl #(.MEM_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  cache_fill_ctrl #(.MEM_LATENCY(6)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 ^ {a[15:4], 4'h0} ^ 16'h1810 ^ {13'h0, a[3:1]};
  endfunction

  // Memory models: fixed-latency shift registers of issued reads
  logic [7:0]  vp0 = '0;
  logic [7:0]  vp1 = '0;
  logic [7:0]  vp2 = '0;
  logic [15:0] ap0 [8];
  logic [15:0] ap1 [8];
  logic [15:0] ap2 [8];
  logic        stray0 = 1'b0;

  always @(posedge clk) begin
    vp0 <= {vp0[6:0], bus0.mem_en};
    vp1 <= {vp1[6:0], bus1.mem_en};
    vp2 <= {vp2[6:0], bus2.mem_en};
    ap0[0] <= bus0.mem_addr;
    ap1[0] <= bus1.mem_addr;
    ap2[0] <= bus2.mem_addr;
    for (int i = 1; i < 8; i++) begin
      ap0[i] <= ap0[i-1];
      ap1[i] <= ap1[i-1];
      ap2[i] <= ap2[i-1];
    end
  end

  assign bus0.mem_data_valid = vp0[3] | stray0;
  assign bus0.mem_data_in    = mem_word(ap0[3]);
  assign bus1.mem_data_valid = vp1[0];
  assign bus1.mem_data_in    = mem_word(ap1[0]);
  assign bus2.mem_data_valid = vp2[5];
  assign bus2.mem_data_in    = mem_word(ap2[5]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard for dut0
  typedef struct {bit own_d; logic [15:0] addr;} iss_t;
  typedef struct {bit own_d; logic [2:0] word; logic [15:0] data;} fil_t;
  iss_t exp_iss[$];
  fil_t exp_fil[$];
  iss_t mon_e;
  fil_t mon_f;
  int   issue_cnt = 0;
  int   tag_cnt   = 0;
  int   tag_cyc   = 0;
  bit   tag_d     = 1'b0;

  task automatic push_fill(input bit d, input logic [15:0] a);
    logic [2:0] kk;
    for (int k = 0; k < 8; k++) begin
      kk = 3'(k);
      exp_iss.push_back('{d, {a[15:4], kk, 1'b0}});
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.mem_en) begin
        issue_cnt++;
        if (exp_iss.size() == 0) begin
          fail_now("unexpected_issue");
        end else begin
          mon_e = exp_iss.pop_front();
          chk("mem_addr", bus0.mem_addr, mon_e.addr);
          exp_fil.push_back('{mon_e.own_d, mon_e.addr[3:1], mem_word(mon_e.addr)});
        end
      end else begin
        chk("idle_mem_addr", bus0.mem_addr, 32'h0);
      end
      if (bus0.fill_we_i || bus0.fill_we_d) begin
        chk("fill_we_excl", bus0.fill_we_i & bus0.fill_we_d, 32'h0);
        if (exp_fil.size() == 0) begin
          fail_now("unexpected_fill");
        end else begin
          mon_f = exp_fil.pop_front();
          chk("fill_owner", bus0.fill_we_d, mon_f.own_d);
          chk("fill_word", bus0.fill_word, mon_f.word);
          chk("fill_data", bus0.fill_data, mon_f.data);
        end
      end
      if (bus0.tag_we_i || bus0.tag_we_d) begin
        chk("tag_we_excl", bus0.tag_we_i & bus0.tag_we_d, 32'h0);
        tag_cnt++;
        tag_cyc = cyc;
        tag_d   = bus0.tag_we_d;
      end
    end
  end

  // Latency-sweep monitors
  logic [15:0] adr1[$];
  logic [15:0] adr2[$];
  int tag1 = -1;
  int tag2 = -1;
  int fills1 = 0;
  int fills2 = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.mem_en) adr1.push_back(bus1.mem_addr);
      if (bus2.mem_en) adr2.push_back(bus2.mem_addr);
      if (bus1.fill_we_i) fills1++;
      if (bus2.fill_we_i) fills2++;
      if (bus1.tag_we_i) tag1 = cyc;
      if (bus2.tag_we_i) tag2 = cyc;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tag(input int prev, input int limit);
    int i;
    i = 0;
    while (tag_cnt == prev && i < limit) begin
      step();
      i++;
    end
    if (tag_cnt == prev) fail_now("tag_timeout");
  endtask

  typedef struct {
    bit          i_req;
    logic [15:0] i_addr;
    bit          d_req;
    logic [15:0] d_addr;
    bit          exp_d;
    logic [15:0] exp_addr;
  } vec_t;
  vec_t tbl[5];

  int n0;
  int tc0;
  int ic0;

  initial begin
    tbl[0] = '{1'b1, 16'h1812, 1'b0, 16'h0000, 1'b0, 16'h1810};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 16'h0413, 1'b1, 16'h0410};
    tbl[2] = '{1'b1, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 16'hFFF0};
    tbl[3] = '{1'b1, 16'hABCD, 1'b1, 16'h000E, 1'b1, 16'h0000};
    tbl[4] = '{1'b1, 16'h7FFE, 1'b0, 16'h1234, 1'b0, 16'h7FF0};

    rst = 1'b1;
    bus0.i_miss = 1'b0; bus0.i_miss_addr = '0; bus0.d_miss = 1'b0; bus0.d_miss_addr = '0;
    bus1.i_miss = 1'b0; bus1.i_miss_addr = '0; bus1.d_miss = 1'b0; bus1.d_miss_addr = '0;
    bus2.i_miss = 1'b0; bus2.i_miss_addr = '0; bus2.d_miss = 1'b0; bus2.d_miss_addr = '0;
    step(2);

    chk("rst_mem_en", bus0.mem_en, 0);
    chk("rst_mem_addr", bus0.mem_addr, 0);
    chk("rst_fill_data", bus0.fill_data, 0);
    chk("rst_fill_word", bus0.fill_word, 0);
    chk("rst_fill_we", {bus0.fill_we_i, bus0.fill_we_d}, 0);
    chk("rst_tag_we", {bus0.tag_we_i, bus0.tag_we_d}, 0);
    chk("rst_busy", bus0.fill_busy, 0);
    rst = 1'b0;
    step(2);
    chk("idle_busy", bus0.fill_busy, 0);

    // Table-driven single fills; requests drop after two ISSUE cycles
    for (int v = 0; v < 5; v++) begin
      n0 = cyc; tc0 = tag_cnt; ic0 = issue_cnt;
      push_fill(tbl[v].exp_d, tbl[v].exp_addr);
      bus0.i_miss = tbl[v].i_req; bus0.i_miss_addr = tbl[v].i_addr;
      bus0.d_miss = tbl[v].d_req; bus0.d_miss_addr = tbl[v].d_addr;
      step(3);
      bus0.i_miss = 1'b0; bus0.d_miss = 1'b0;
      bus0.i_miss_addr = 16'hDEAD; bus0.d_miss_addr = 16'hBEEF;
      chk("busy_mid", bus0.fill_busy, 1);
      wait_tag(tc0, 30);
      chk("done_cycle", tag_cyc - n0, 13);
      chk("tag_owner", tag_d, tbl[v].exp_d);
      step(2);
      chk("busy_after", bus0.fill_busy, 0);
      chk("issue_count", issue_cnt - ic0, 8);
      chk("tag_count", tag_cnt - tc0, 1);
      chk("sb_empty", exp_iss.size() + exp_fil.size(), 0);
    end

    // Priority: D first, pending I granted the cycle after DONE
    n0 = cyc; tc0 = tag_cnt;
    push_fill(1'b1, 16'h0410);
    push_fill(1'b0, 16'h1810);
    bus0.d_miss = 1'b1; bus0.d_miss_addr = 16'h0413;
    bus0.i_miss = 1'b1; bus0.i_miss_addr = 16'h1812;
    step(3);
    bus0.d_miss = 1'b0;
    wait_tag(tc0, 30);
    chk("prio_d_done", tag_cyc - n0, 13);
    chk("prio_d_owner", tag_d, 1);
    step(3);
    bus0.i_miss = 1'b0;
    wait_tag(tc0 + 1, 30);
    chk("prio_i_done", tag_cyc - n0, 27);
    chk("prio_i_owner", tag_d, 0);
    step(2);
    chk("prio_sb_empty", exp_iss.size() + exp_fil.size(), 0);
    chk("prio_busy", bus0.fill_busy, 0);

    // Stray data in IDLE
    step(2);
    stray0 = 1'b1;
    #2;
    chk("stray_we", {bus0.fill_we_i, bus0.fill_we_d}, 0);
    chk("stray_busy", bus0.fill_busy, 0);
    step();
    stray0 = 1'b0;
    step();
    chk("stray_idle", bus0.fill_busy, 0);

    // Reset mid-ISSUE
    n0 = cyc; tc0 = tag_cnt;
    push_fill(1'b0, 16'h1810);
    bus0.i_miss = 1'b1; bus0.i_miss_addr = 16'h1812;
    step(3);
    chk("pre_rst_mem_en", bus0.mem_en, 1);
    exp_iss.delete();
    exp_fil.delete();
    rst = 1'b1;
    bus0.i_miss = 1'b0;
    #1;
    chk("rst_mid_mem_en", bus0.mem_en, 0);
    chk("rst_mid_busy", bus0.fill_busy, 0);
    chk("rst_mid_tag", {bus0.tag_we_i, bus0.tag_we_d}, 0);
    chk("rst_mid_addr", bus0.mem_addr, 0);
    step(2);
    rst = 1'b0;
    step(12);
    chk("post_rst_busy", bus0.fill_busy, 0);
    chk("post_rst_tag", tag_cnt - tc0, 0);
    chk("post_rst_mem_en", bus0.mem_en, 0);

    // Latency sweep on L=1 and L=6 instances
    n0 = cyc;
    bus1.i_miss = 1'b1; bus1.i_miss_addr = 16'h0001;
    bus2.i_miss = 1'b1; bus2.i_miss_addr = 16'h0001;
    step(3);
    bus1.i_miss = 1'b0; bus2.i_miss = 1'b0;
    for (int i = 0; i < 40 && tag2 < 0; i++) step();
    if (tag1 < 0) fail_now("sweep_l1_timeout");
    if (tag2 < 0) fail_now("sweep_l6_timeout");
    chk("sweep_l1_done", tag1 - n0, 10);
    chk("sweep_l6_done", tag2 - n0, 15);
    chk("sweep_l1_fills", fills1, 8);
    chk("sweep_l6_fills", fills2, 8);
    chk("sweep_l1_issues", adr1.size(), 8);
    chk("sweep_l6_issues", adr2.size(), 8);
    for (int k = 0; k < 8 && k < adr1.size(); k++) chk("sweep_l1_addr", adr1[k], 2 * k);
    for (int k = 0; k < 8 && k < adr2.size(); k++) chk("sweep_l6_addr", adr2[k], 2 * k);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    fail_now("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
